accel_call_seq: RTL

ACCEL_CALL_SEQ -- requirements
Module: accel_call_seq

---
 rtl/accel_seq_pkg.sv | 24 ++
 rtl/call_watchdog.sv | 43 ++++
 rtl/accel_call_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/accel_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accel_seq_pkg
// Description : Shared call-state encoding and default sizing for the
//               accelerator call sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package accel_seq_pkg;

   localparam int C_DEFAULT_DATA_W         = 32;
   localparam int C_DEFAULT_CNT_W          = 32;
   localparam int C_DEFAULT_TIMEOUT_CYCLES = 1024;
   localparam int STATE_W                  = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      RUN   = 3'd2,
      ABORT = 3'd3,
      RESP  = 3'd4
   } call_state_e;

endpackage
`default_nettype wire

// File: rtl/call_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : call_watchdog
// Description : Saturating RUN-cycle counter with expiry flag raised on the
//               cycle whose post-increment count reaches TIMEOUT_CYCLES.
// Revision    : 1.0 - initial release
// ============================================================================
module call_watchdog #(
   parameter int CNT_W          = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_enable,
   output logic [CNT_W-1:0] o_count_next,
   output logic             o_expire
);

   localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
   localparam logic [CNT_W:0]   C_ONE_X = (CNT_W+1)'(1);
   localparam logic [CNT_W:0]   C_LIMIT = (CNT_W+1)'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] r_count;
   logic             w_sat;

   assign w_sat        = &r_count;
   assign o_count_next = w_sat ? r_count : r_count + C_ONE;
   // Compare one bit wider so a limit of 2^CNT_W never aliases to zero
   assign o_expire     = i_enable && (({1'b0, r_count} + C_ONE_X) == C_LIMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && !w_sat) begin
         r_count <= r_count + C_ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/accel_call_seq.sv
`default_nettype none
// ============================================================================
// Module      : accel_call_seq
// Description : Issues one accelerator call per request, watches it with a
//               watchdog, and returns result, timeout flag and cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_call_seq
   import accel_seq_pkg::*;
#(
   parameter int DATA_W         = C_DEFAULT_DATA_W,
   parameter int TIMEOUT_CYCLES = C_DEFAULT_TIMEOUT_CYCLES,
   parameter int CNT_W          = C_DEFAULT_CNT_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [DATA_W-1:0] req_arg,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_timeout,
   output logic [CNT_W-1:0]  rsp_cycles,
   output logic              accel_start,
   input  logic              accel_ready,
   input  logic              accel_finish,
   input  logic [DATA_W-1:0] accel_return_val,
   output logic [DATA_W-1:0] accel_n,
   output logic              accel_reset,
   output logic              busy
);

   call_state_e       r_state;
   logic [DATA_W-1:0] r_accel_n;
   logic [DATA_W-1:0] r_rsp_data;
   logic              r_rsp_timeout;
   logic [CNT_W-1:0]  r_rsp_cycles;
   logic              r_abort_cnt;

   logic              w_start_accept;
   logic              w_in_run;
   logic [CNT_W-1:0]  w_cnt_next;
   logic              w_expire;

   assign w_start_accept = (r_state == START) && accel_ready;
   assign w_in_run       = (r_state == RUN);

   call_watchdog #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk          (clk),
      .reset        (reset),
      .i_clear      (w_start_accept),
      .i_enable     (w_in_run),
      .o_count_next (w_cnt_next),
      .o_expire     (w_expire)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_accel_n     <= '0;
         r_rsp_data    <= '0;
         r_rsp_timeout <= 1'b0;
         r_rsp_cycles  <= '0;
         r_abort_cnt   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_accel_n <= req_arg;
                  r_state   <= START;
               end
            end
            START: begin
               if (accel_ready) begin
                  r_state <= RUN;
               end
            end
            RUN: begin
               // A finish landing on the expiry cycle still counts as success
               if (accel_finish) begin
                  r_rsp_data    <= accel_return_val;
                  r_rsp_cycles  <= w_cnt_next;
                  r_rsp_timeout <= 1'b0;
                  r_state       <= RESP;
               end else if (w_expire) begin
                  r_rsp_data    <= '0;
                  r_rsp_cycles  <= w_cnt_next;
                  r_rsp_timeout <= 1'b1;
                  r_abort_cnt   <= 1'b0;
                  r_state       <= ABORT;
               end
            end
            ABORT: begin
               if (r_abort_cnt) begin
                  r_state <= RESP;
               end else begin
                  r_abort_cnt <= 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign req_ready   = (r_state == IDLE);
   assign rsp_valid   = (r_state == RESP);
   assign rsp_data    = r_rsp_data;
   assign rsp_timeout = r_rsp_timeout;
   assign rsp_cycles  = r_rsp_cycles;
   assign accel_start = (r_state == START);
   assign accel_n     = r_accel_n;
   assign accel_reset = reset || (r_state == ABORT);
   assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire
